// File: rtl/popcnt_pkg.sv
// popcnt_pkg: shared constants, FSM state type and width helpers
// for popcnt_sequencer. Optional DRAIN state: POPCNT_SORTER_PIPE_EN.
package popcnt_pkg;

  localparam int SORTER_W = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
`ifdef POPCNT_SORTER_PIPE_EN
    DRAIN = 2'd2,
`endif
    DONE  = 2'd3
  } popcnt_state_t;

  function automatic int chunks(int data_w);
    return (data_w + SORTER_W - 1) / SORTER_W;
  endfunction

  function automatic int cnt_w(int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/popcnt_sequencer_if.sv
// popcnt_sequencer_if: valid/ready word in, count out, busy flag.
// master = producer/consumer side, slave = popcnt_sequencer.
interface popcnt_sequencer_if
  import popcnt_pkg::*;
#(
  parameter int DATA_W = 60
);
  localparam int CNT_W = cnt_w(DATA_W);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_count;
  logic              busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_count, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_count, busy
  );
endinterface

// File: rtl/fifteen_sorter.sv
// fifteen_sorter: 15-input bit sorter, ascending (out1 lowest).
// Ports: in1..in15 unsorted bits, out1..out15 sorted bits.
module fifteen_sorter (
  input  logic in1,  in2,  in3,  in4,  in5,
  input  logic in6,  in7,  in8,  in9,  in10,
  input  logic in11, in12, in13, in14, in15,
  output logic out1,  out2,  out3,  out4,  out5,
  output logic out6,  out7,  out8,  out9,  out10,
  output logic out11, out12, out13, out14, out15
);
  logic [14:0] v;
  logic        t;

  // Bubble network of compare-exchange cells: AND low, OR high.
  always_comb begin
    t = 1'b0;
    v = {in15, in14, in13, in12, in11, in10, in9, in8,
         in7, in6, in5, in4, in3, in2, in1};
    for (int i = 0; i < 14; i++) begin
      for (int j = 0; j < 14 - i; j++) begin
        t      = v[j];
        v[j]   = t & v[j+1];
        v[j+1] = t | v[j+1];
      end
    end
  end

  assign {out15, out14, out13, out12, out11, out10, out9, out8,
          out7, out6, out5, out4, out3, out2, out1} = v;
endmodule

// File: rtl/thermo15_to_bin.sv
// thermo15_to_bin: ascending 15-bit thermometer to 4-bit count.
// Ports: thermo (bit 0 = out1), bin (0..15). Combinational.
module thermo15_to_bin (
  input  logic [14:0] thermo,
  output logic [3:0]  bin
);
  always_comb begin
    bin = '0;
    for (int i = 0; i < 15; i++) begin
      bin = bin + {3'b000, thermo[i]};
    end
  end
endmodule

// File: rtl/popcnt_sequencer.sv
// popcnt_sequencer: multi-cycle popcount, one 15-bit slice per cycle.
// Ports: clk, rst (sync, active-high), bus (slave). Macro: POPCNT_SORTER_PIPE_EN.
module popcnt_sequencer
  import popcnt_pkg::*;
#(
  parameter int DATA_W = 60
) (
  input logic               clk,
  input logic               rst,
  popcnt_sequencer_if.slave bus
);
  localparam int CHUNKS = chunks(DATA_W);
  localparam int CNT_W  = cnt_w(DATA_W);
  localparam int PAD_W  = CHUNKS * SORTER_W;
  localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  popcnt_state_t       state;
  logic [PAD_W-1:0]    word;
  logic [IDX_W-1:0]    idx;
  logic [CNT_W-1:0]    acc;
  logic                rdy;
  logic [SORTER_W-1:0] sorted;
  logic [3:0]          slice_cnt;
  logic [3:0]          add_cnt;
  logic [CNT_W-1:0]    sum;
  logic                last;

  // Word shifts right each RUN cycle, so the live slice is word[14:0].
  fifteen_sorter u_sort (
    .in1  (word[0]),  .in2  (word[1]),  .in3  (word[2]),
    .in4  (word[3]),  .in5  (word[4]),  .in6  (word[5]),
    .in7  (word[6]),  .in8  (word[7]),  .in9  (word[8]),
    .in10 (word[9]),  .in11 (word[10]), .in12 (word[11]),
    .in13 (word[12]), .in14 (word[13]), .in15 (word[14]),
    .out1 (sorted[0]),  .out2 (sorted[1]),  .out3 (sorted[2]),
    .out4 (sorted[3]),  .out5 (sorted[4]),  .out6 (sorted[5]),
    .out7 (sorted[6]),  .out8 (sorted[7]),  .out9 (sorted[8]),
    .out10(sorted[9]),  .out11(sorted[10]), .out12(sorted[11]),
    .out13(sorted[12]), .out14(sorted[13]), .out15(sorted[14])
  );

  thermo15_to_bin u_thermo (
    .thermo(sorted),
    .bin   (slice_cnt)
  );

`ifdef POPCNT_SORTER_PIPE_EN
  logic [3:0] pipe;
  assign add_cnt = pipe;
`else
  assign add_cnt = slice_cnt;
`endif

  // Slice counts never exceed the ones present, so no overflow.
  assign sum  = acc + CNT_W'(add_cnt);
  assign last = (idx == IDX_W'(CHUNKS - 1));

  assign bus.in_ready = rdy & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      word          <= '0;
      idx           <= '0;
      acc           <= '0;
      rdy           <= 1'b1;
      bus.busy      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_count <= '0;
`ifdef POPCNT_SORTER_PIPE_EN
      pipe          <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            word     <= PAD_W'(bus.in_data);
            acc      <= '0;
            idx      <= '0;
            rdy      <= 1'b0;
            bus.busy <= 1'b1;
            state    <= RUN;
`ifdef POPCNT_SORTER_PIPE_EN
            pipe     <= '0;
`endif
          end
        end
        RUN: begin
          acc  <= sum;
          word <= word >> SORTER_W;
          idx  <= idx + IDX_W'(1);
`ifdef POPCNT_SORTER_PIPE_EN
          pipe <= slice_cnt;
          if (last) state <= DRAIN;
`else
          if (last) begin
            state         <= DONE;
            bus.busy      <= 1'b0;
            bus.out_valid <= 1'b1;
            bus.out_count <= sum;
          end
`endif
        end
`ifdef POPCNT_SORTER_PIPE_EN
        DRAIN: begin
          acc           <= sum;
          state         <= DONE;
          bus.busy      <= 1'b0;
          bus.out_valid <= 1'b1;
          bus.out_count <= sum;
        end
`endif
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            rdy           <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
